dr32e_id_controller: RTL and testbench

- Main control FSM for the dr32e decode (ID) stage. Sits beside dr32e_decoder and sequences instruction acceptance, stalls, PC redirects, exceptions, interrupts and sleep.
- Consumes decoder classification flags plus the registered branch decision. Drives IF-stage PC-set/flush controls and CSR save/restore strobes.
- Keeps a retired-instruction counter.

---
 rtl/dr32e_pkg.sv | 28 ++
 rtl/dr32e_id_controller.sv | 191 +++++++++++++++++++
 tb/tb_dr32e_id_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dr32e_pkg.sv
// Shared types for the dr32e decode-stage control path.
package dr32e_pkg;

    typedef enum logic [2:0] {
        RESET,
        BOOT,
        DECODE,
        MULTI,
        FLUSH,
        SLEEP
    } ctrl_fsm_e;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_JUMP = 2'd1,
        PC_EXC  = 2'd2,
        PC_ERET = 2'd3
    } pc_sel_e;

    typedef enum logic [5:0] {
        EXC_NONE    = 6'd0,
        EXC_ILLEGAL = 6'd2,
        EXC_BREAK   = 6'd3,
        EXC_ECALL   = 6'd11,
        IRQ_EXT     = {1'b1, 5'd11}
    } exc_cause_e;

endpackage

// File: rtl/dr32e_id_controller.sv
// Decode-stage control FSM: boot sequencing, redirects, exceptions, interrupts,
// WFI sleep, multicycle stalls and the retired-instruction counter.
module dr32e_id_controller
    import dr32e_pkg::*;
#(
    parameter int unsigned BootDelay = 4,
    parameter logic [4:0]  IrqCause  = 5'd11
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    input  logic        instr_valid_i,
    input  logic        illegal_insn_i,
    input  logic        illegal_c_insn_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        wfi_i,
    input  logic        jump_in_dec_i,
    input  logic        branch_in_dec_i,
    input  logic        branch_taken_i,
    input  logic        multicycle_i,
    input  logic        ex_done_i,
    input  logic        irq_pending_i,
    input  logic        irq_enable_i,
    output logic        instr_req_o,
    output logic        id_ready_o,
    output logic        pc_set_o,
    output logic [1:0]  pc_mux_o,
    output logic [5:0]  exc_cause_o,
    output logic        csr_save_o,
    output logic        csr_restore_mret_o,
    output logic        flush_id_o,
    output logic        stall_o,
    output logic        retire_o,
    output logic [31:0] instret_o,
    output logic        sleeping_o
);

    localparam logic [3:0] BootLast = 4'(BootDelay - 1);

    ctrl_fsm_e   state_q, state_d;
    pc_sel_e     pc_sel_q;
    logic [3:0]  boot_cnt;
    logic [31:0] instret_q;
    logic        exc_hit;
    logic [5:0]  exc_code;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RESET;
            pc_sel_q  <= PC_BOOT;
            boot_cnt  <= 4'd0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == RESET)
                boot_cnt <= 4'd0;
            else if (state_q == BOOT)
                boot_cnt <= boot_cnt + 4'd1;
            if (pc_set_o)
                pc_sel_q <= pc_sel_e'(pc_mux_o);
            if (retire_o)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_o = instret_q;

    // Exception selection in priority order; only consulted in DECODE.
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = EXC_NONE;
        if (irq_pending_i && irq_enable_i)
            exc_code = {1'b1, IrqCause};
        else if (illegal_insn_i || illegal_c_insn_i)
            exc_code = EXC_ILLEGAL;
        else if (ecall_i)
            exc_code = EXC_ECALL;
        else if (ebreak_i)
            exc_code = EXC_BREAK;
        else
            exc_hit = 1'b0;
    end

    always_comb begin
        state_d            = state_q;
        instr_req_o        = 1'b0;
        id_ready_o         = 1'b0;
        pc_set_o           = 1'b0;
        pc_mux_o           = pc_sel_q;
        exc_cause_o        = 6'd0;
        csr_save_o         = 1'b0;
        csr_restore_mret_o = 1'b0;
        flush_id_o         = 1'b0;
        stall_o            = 1'b0;
        retire_o           = 1'b0;
        sleeping_o         = 1'b0;

        unique case (state_q)
            RESET: begin
                if (fetch_enable_i)
                    state_d = BOOT;
            end
            BOOT: begin
                if (boot_cnt == BootLast) begin
                    pc_set_o = 1'b1;
                    pc_mux_o = PC_BOOT;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                instr_req_o = 1'b1;
                id_ready_o  = 1'b1;
                if (instr_valid_i) begin
                    if (exc_hit) begin
                        pc_set_o    = 1'b1;
                        pc_mux_o    = PC_EXC;
                        exc_cause_o = exc_code;
                        csr_save_o  = 1'b1;
                        flush_id_o  = 1'b1;
                        id_ready_o  = 1'b0;
                        state_d     = FLUSH;
                    end else if (mret_i) begin
                        pc_set_o           = 1'b1;
                        pc_mux_o           = PC_ERET;
                        csr_restore_mret_o = 1'b1;
                        flush_id_o         = 1'b1;
                        retire_o           = 1'b1;
                        id_ready_o         = 1'b0;
                        state_d            = FLUSH;
                    end else if (jump_in_dec_i || (branch_in_dec_i && branch_taken_i)) begin
                        pc_set_o   = 1'b1;
                        pc_mux_o   = PC_JUMP;
                        flush_id_o = 1'b1;
                        retire_o   = 1'b1;
                        id_ready_o = 1'b0;
                        state_d    = FLUSH;
                    end else if (wfi_i) begin
                        retire_o = 1'b1;
                        state_d  = SLEEP;
                    end else if (multicycle_i && !ex_done_i) begin
                        stall_o    = 1'b1;
                        id_ready_o = 1'b0;
                        state_d    = MULTI;
                    end else begin
                        retire_o = 1'b1;
                    end
                end
            end
            MULTI: begin
                instr_req_o = 1'b1;
                if (ex_done_i) begin
                    retire_o   = 1'b1;
                    id_ready_o = 1'b1;
                    state_d    = DECODE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            FLUSH: begin
                instr_req_o = 1'b1;
                flush_id_o  = 1'b1;
                state_d     = DECODE;
            end
            SLEEP: begin
                sleeping_o = 1'b1;
                // Wake on any pending request; MIE only gates taking it as a trap.
                if (irq_pending_i)
                    state_d = DECODE;
            end
            default: state_d = RESET;
        endcase

        // Suppress every strobe while reset is held so nothing retires or redirects.
        if (!rst_ni) begin
            instr_req_o        = 1'b0;
            id_ready_o         = 1'b0;
            pc_set_o           = 1'b0;
            pc_mux_o           = pc_sel_q;
            exc_cause_o        = 6'd0;
            csr_save_o         = 1'b0;
            csr_restore_mret_o = 1'b0;
            flush_id_o         = 1'b0;
            stall_o            = 1'b0;
            retire_o           = 1'b0;
            sleeping_o         = 1'b0;
        end
    end

endmodule

// File: tb/tb_dr32e_id_controller.sv
// Scoreboard bench for dr32e_id_controller: driver queues per-cycle expected outputs,
// monitor compares them on the falling edge.
module tb_dr32e_id_controller;

    logic        clk = 1'b0;
    logic        rst_ni, fetch_enable_i, instr_valid_i, illegal_insn_i, illegal_c_insn_i;
    logic        ecall_i, ebreak_i, mret_i, wfi_i, jump_in_dec_i, branch_in_dec_i;
    logic        branch_taken_i, multicycle_i, ex_done_i, irq_pending_i, irq_enable_i;
    logic        instr_req_o, id_ready_o, pc_set_o, csr_save_o, csr_restore_mret_o;
    logic        flush_id_o, stall_o, retire_o, sleeping_o;
    logic [1:0]  pc_mux_o;
    logic [5:0]  exc_cause_o;
    logic [31:0] instret_o;

    always #5 clk = ~clk;

    dr32e_id_controller #(.BootDelay(4), .IrqCause(5'd11)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
        .instr_valid_i(instr_valid_i), .illegal_insn_i(illegal_insn_i),
        .illegal_c_insn_i(illegal_c_insn_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
        .mret_i(mret_i), .wfi_i(wfi_i), .jump_in_dec_i(jump_in_dec_i),
        .branch_in_dec_i(branch_in_dec_i), .branch_taken_i(branch_taken_i),
        .multicycle_i(multicycle_i), .ex_done_i(ex_done_i), .irq_pending_i(irq_pending_i),
        .irq_enable_i(irq_enable_i), .instr_req_o(instr_req_o), .id_ready_o(id_ready_o),
        .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o), .exc_cause_o(exc_cause_o),
        .csr_save_o(csr_save_o), .csr_restore_mret_o(csr_restore_mret_o),
        .flush_id_o(flush_id_o), .stall_o(stall_o), .retire_o(retire_o),
        .instret_o(instret_o), .sleeping_o(sleeping_o)
    );

    // {req, rdy, set, mux, cause, save, restore, flush, stall, retire, sleep, instret}
    typedef logic [49:0] obs_t;
    typedef struct {
        string nm;
        obs_t  o;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    obs_t got;
    int   checks = 0;
    int   failures = 0;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            got = {instr_req_o, id_ready_o, pc_set_o, pc_mux_o, exc_cause_o, csr_save_o,
                   csr_restore_mret_o, flush_id_o, stall_o, retire_o, sleeping_o, instret_o};
            checks++;
            if (got !== e.o) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.nm, got, e.o);
            end
        end
    end

    task automatic clr();
        instr_valid_i = 0; illegal_insn_i = 0; illegal_c_insn_i = 0; ecall_i = 0;
        ebreak_i = 0; mret_i = 0; wfi_i = 0; jump_in_dec_i = 0; branch_in_dec_i = 0;
        branch_taken_i = 0; multicycle_i = 0; ex_done_i = 0; irq_pending_i = 0;
        irq_enable_i = 0;
    endtask

    // Queue this cycle's expectation, then advance one clock.
    task automatic cyc(input string nm, input logic req, input logic rdy, input logic set,
                       input logic [1:0] mux, input logic [5:0] cause, input logic save,
                       input logic rest, input logic flush, input logic stall,
                       input logic ret, input logic slp, input logic [31:0] cnt);
        exp_t x;
        x.nm = nm;
        x.o  = {req, rdy, set, mux, cause, save, rest, flush, stall, ret, slp, cnt};
        expq.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        clr();
        rst_ni = 0; fetch_enable_i = 0;
        repeat (3) @(posedge clk);
        #1;
        cyc("rst_held",   0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        rst_ni = 1;
        cyc("reset_idle", 0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        fetch_enable_i = 1;
        cyc("boot_c1",    0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        cyc("boot_c2",    0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        cyc("boot_c3",    0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        cyc("boot_c4",    0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        cyc("boot_pc",    0,0,1,2'd0,6'h00,0,0,0,0,0,0,32'd0);
        cyc("dec_idle",   1,1,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);

        // Interrupt beats illegal when enabled
        instr_valid_i = 1; illegal_insn_i = 1; irq_pending_i = 1; irq_enable_i = 1;
        cyc("irq_ill",    1,0,1,2'd2,6'h2B,1,0,1,0,0,0,32'd0);
        clr();
        cyc("irq_flush",  1,0,0,2'd2,6'h00,0,0,1,0,0,0,32'd0);
        instr_valid_i = 1; illegal_insn_i = 1; irq_pending_i = 1;
        cyc("ill_noen",   1,0,1,2'd2,6'h02,1,0,1,0,0,0,32'd0);
        clr();
        cyc("ill_flush",  1,0,0,2'd2,6'h00,0,0,1,0,0,0,32'd0);
        instr_valid_i = 1; illegal_c_insn_i = 1;
        cyc("ill_c",      1,0,1,2'd2,6'h02,1,0,1,0,0,0,32'd0);
        clr();
        cyc("illc_flush", 1,0,0,2'd2,6'h00,0,0,1,0,0,0,32'd0);
        instr_valid_i = 1; ecall_i = 1;
        cyc("ecall",      1,0,1,2'd2,6'h0B,1,0,1,0,0,0,32'd0);
        clr();
        cyc("ecall_fl",   1,0,0,2'd2,6'h00,0,0,1,0,0,0,32'd0);
        instr_valid_i = 1; ebreak_i = 1;
        cyc("ebreak",     1,0,1,2'd2,6'h03,1,0,1,0,0,0,32'd0);
        clr();
        cyc("ebreak_fl",  1,0,0,2'd2,6'h00,0,0,1,0,0,0,32'd0);

        instr_valid_i = 1; mret_i = 1;
        cyc("mret",       1,0,1,2'd3,6'h00,0,1,1,0,1,0,32'd0);
        clr();
        cyc("mret_fl",    1,0,0,2'd3,6'h00,0,0,1,0,0,0,32'd1);

        instr_valid_i = 1; branch_in_dec_i = 1; branch_taken_i = 1;
        cyc("br_taken",   1,0,1,2'd1,6'h00,0,0,1,0,1,0,32'd1);
        clr();
        cyc("br_tk_fl",   1,0,0,2'd1,6'h00,0,0,1,0,0,0,32'd2);
        instr_valid_i = 1; branch_in_dec_i = 1;
        cyc("br_nt",      1,1,0,2'd1,6'h00,0,0,0,0,1,0,32'd2);
        clr();
        cyc("br_nt_idle", 1,1,0,2'd1,6'h00,0,0,0,0,0,0,32'd3);

        instr_valid_i = 1; multicycle_i = 1;
        cyc("mc_dec",     1,0,0,2'd1,6'h00,0,0,0,1,0,0,32'd3);
        clr(); irq_pending_i = 1; irq_enable_i = 1;
        cyc("mc_wait1",   1,0,0,2'd1,6'h00,0,0,0,1,0,0,32'd3);
        clr();
        cyc("mc_wait2",   1,0,0,2'd1,6'h00,0,0,0,1,0,0,32'd3);
        ex_done_i = 1;
        cyc("mc_done",    1,1,0,2'd1,6'h00,0,0,0,0,1,0,32'd3);
        clr();
        cyc("mc_idle",    1,1,0,2'd1,6'h00,0,0,0,0,0,0,32'd4);
        instr_valid_i = 1; multicycle_i = 1; ex_done_i = 1;
        cyc("mc_fast",    1,1,0,2'd1,6'h00,0,0,0,0,1,0,32'd4);
        clr(); irq_pending_i = 1; irq_enable_i = 1;
        cyc("irq_noval",  1,1,0,2'd1,6'h00,0,0,0,0,0,0,32'd5);

        clr(); instr_valid_i = 1; wfi_i = 1;
        cyc("wfi",        1,1,0,2'd1,6'h00,0,0,0,0,1,0,32'd5);
        clr();
        cyc("sleep",      0,0,0,2'd1,6'h00,0,0,0,0,0,1,32'd6);
        irq_pending_i = 1;
        cyc("sleep_irq",  0,0,0,2'd1,6'h00,0,0,0,0,0,1,32'd6);
        cyc("woken",      1,1,0,2'd1,6'h00,0,0,0,0,0,0,32'd6);

        clr();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        instr_valid_i = 1;
        cyc("wrap_ret",   1,1,0,2'd1,6'h00,0,0,0,0,1,0,32'hFFFF_FFFF);
        clr();
        cyc("wrap_zero",  1,1,0,2'd1,6'h00,0,0,0,0,0,0,32'd0);

        instr_valid_i = 1; multicycle_i = 1; instr_valid_i = 1;
        cyc("rst_mc",     1,0,0,2'd1,6'h00,0,0,0,1,0,0,32'd0);
        clr(); rst_ni = 0;
        step();
        rst_ni = 1; fetch_enable_i = 0;
        cyc("rst_mid",    0,0,0,2'd0,6'h00,0,0,0,0,0,0,32'd0);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
